// File: rtl/wb_dest_arbiter_pkg.sv
// Shared types and constants for the writeback destination arbiter.
// Imported by rr_pick4 and wb_dest_arbiter.
package wb_arb_pkg;

    localparam int NUM_REQ = 4;

    // Select codes of the write-register-address mux (rt, rd, $ra, aux).
    localparam logic [1:0] SEL_RT  = 2'd0;
    localparam logic [1:0] SEL_RD  = 2'd1;
    localparam logic [1:0] SEL_RA  = 2'd2;
    localparam logic [1:0] SEL_AUX = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/wb_dest_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first unmasked request at or above ptr
// (modulo 4) wins.
module rr_pick4
    import wb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [1:0]         ptr,
    output logic [1:0]         winner,
    output logic               valid
);

    logic [1:0] idx;

    // Scan from the farthest offset down so the closest candidate is written last.
    always_comb begin
        winner = ptr;
        valid  = 1'b0;
        idx    = 2'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx] && !mask[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_dest_arbiter.sv
// Round-robin arbiter for the register-file write port with lock and stall freeze.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest, no pointer).
module wb_dest_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 4,
    parameter int unsigned PTR_RST  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    input  logic               stall,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         sel,
    output logic               wr_en,
    output logic               busy,
    output logic               lock_err
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               lock_err_q, lock_err_d;

    logic [1:0]         pick_ptr;
    logic [NUM_REQ-1:0] pick_mask;
    logic [1:0]         pick_win;
    logic               pick_valid;
    logic               held_req;
    logic               can_extend;

`ifndef WB_ARB_FIXED_PRIO_EN
    logic [1:0] ptr_q, ptr_d;
`endif

    // While busy, the picker looks ahead at the release case: start after the
    // current holder and ignore its still-high request for this one edge.
    always_comb begin
`ifdef WB_ARB_FIXED_PRIO_EN
        pick_ptr = 2'd0;
`else
        pick_ptr = (state_q == IDLE) ? ptr_q : sel_q + 2'd1;
`endif
        pick_mask = (state_q == IDLE) ? '0 : idx_to_onehot(sel_q);
    end

    rr_pick4 u_pick (
        .req    (req),
        .mask   (pick_mask),
        .ptr    (pick_ptr),
        .winner (pick_win),
        .valid  (pick_valid)
    );

    assign held_req   = lock[sel_q] & req[sel_q];
    assign can_extend = held_req && (cnt_q < 4'(LOCK_MAX - 1));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        lock_err_d = 1'b0;
`ifndef WB_ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_d = GRANT;
                        gnt_d   = idx_to_onehot(pick_win);
                        sel_d   = pick_win;
                    end
                end
                GRANT, LOCKED: begin
                    if (can_extend) begin
                        state_d = LOCKED;
                        cnt_d   = cnt_q + 4'd1;
                    end else begin
                        cnt_d      = 4'd0;
                        lock_err_d = held_req;
`ifndef WB_ARB_FIXED_PRIO_EN
                        ptr_d      = sel_q + 2'd1;
`endif
                        if (pick_valid) begin
                            state_d = GRANT;
                            gnt_d   = idx_to_onehot(pick_win);
                            sel_d   = pick_win;
                        end else begin
                            state_d = IDLE;
                            gnt_d   = '0;
                            sel_d   = SEL_RT;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    sel_d   = SEL_RT;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= SEL_RT;
            cnt_q      <= 4'd0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            lock_err_q <= lock_err_d;
        end
    end

`ifndef WB_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'(PTR_RST);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign busy     = (state_q != IDLE);
    assign wr_en    = busy & ~stall;
    assign lock_err = lock_err_q;

endmodule

// File: tb/tb_wb_dest_arbiter.sv
// Self-checking bench for wb_dest_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_wb_dest_arbiter;

    localparam int LOCK_MAX_TB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       stall;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       wr_en;
    logic       busy;
    logic       lock_err;

    int n_cmp;
    int n_fail;

    // Reference model: current holder (-1 = none), cycles held, priority start.
    int m_cur;
    int m_used;
    int m_ptr;
    int m_rel;
    bit m_err;

    wb_dest_arbiter #(
        .LOCK_MAX (LOCK_MAX_TB),
        .PTR_RST  (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .stall    (stall),
        .gnt      (gnt),
        .sel      (sel),
        .wr_en    (wr_en),
        .busy     (busy),
        .lock_err (lock_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_pick(int start, int skip, logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (i != skip && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cur  = -1;
        m_used = 0;
        m_ptr  = 0;
        m_rel  = -1;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        m_err = 1'b0;
        m_rel = -1;
        if (!stall) begin
            if (m_cur < 0) begin
                m_cur  = model_pick(m_ptr, -1, req);
                m_used = 1;
            end else if (lock[m_cur] && req[m_cur] && m_used < LOCK_MAX_TB) begin
                m_used++;
            end else begin
                m_err = lock[m_cur] && req[m_cur];
                m_rel = m_cur;
`ifdef WB_ARB_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (m_cur + 1) % 4;
`endif
                m_cur  = model_pick(m_ptr, m_rel, req);
                m_used = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        lock  = 4'b0000;
        stall = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        req   = 4'b0000;
        lock  = 4'b0000;
        stall = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, sel, wr_en, busy, lock_err} !== 9'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: got gnt=%b sel=%0d wr_en=%b busy=%b lock_err=%b, expected all 0",
                     gnt, sel, wr_en, busy, lock_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({gnt, sel, wr_en, busy, lock_err} !== 9'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_idle_c%0d: got gnt=%b sel=%0d wr_en=%b busy=%b lock_err=%b, expected all 0",
                         c, gnt, sel, wr_en, busy, lock_err);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        n_cmp++;
        if (gnt !== 4'b0010 || sel !== 2'd1 || wr_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got gnt=%b sel=%0d wr_en=%b busy=%b, expected 0010/1/1/1",
                     gnt, sel, wr_en, busy);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || wr_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_release: got gnt=%b wr_en=%b busy=%b, expected 0000/0/0",
                     gnt, wr_en, busy);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_g;
        int         writes;
        do_reset();
        writes = 0;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k > 0) req[k-1] = 1'b0;
            exp_g = 4'b0001 << k;
            writes += int'(wr_en);
            n_cmp++;
            if (gnt !== exp_g || sel !== 2'(k) || wr_en !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL contention_k%0d: got gnt=%b sel=%0d wr_en=%b, expected %b/%0d/1",
                         k, gnt, sel, wr_en, exp_g, k);
            end
        end
        tick();
        req = 4'b0000;
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || writes != 4) begin
            n_fail++;
            $display("[TB] FAIL contention_end: got busy=%b gnt=%b writes=%0d, expected 0/0000/4",
                     busy, gnt, writes);
        end
    endtask

    task automatic test_lock();
        do_reset();
        req  = 4'b1100;
        lock = 4'b0100;
        for (int k = 1; k <= LOCK_MAX_TB; k++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0100 || sel !== 2'd2 || lock_err !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL lock_hold_c%0d: got gnt=%b sel=%0d lock_err=%b, expected 0100/2/0",
                         k, gnt, sel, lock_err);
            end
        end
        tick();
        req[2]  = 1'b0;
        lock[2] = 1'b0;
        n_cmp++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || lock_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL lock_forced: got gnt=%b sel=%0d lock_err=%b, expected 1000/3/1",
                     gnt, sel, lock_err);
        end
        tick();
        req = 4'b0000;
        n_cmp++;
        if (lock_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lock_err_pulse: got lock_err=%b busy=%b, expected 0/0", lock_err, busy);
        end
    endtask

    task automatic test_stall();
        int writes;
        do_reset();
        req = 4'b0001;
        tick();
        writes = 0;
        stall  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            writes += int'(wr_en);
            n_cmp++;
            if (gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1 || wr_en !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall_freeze_c%0d: got gnt=%b sel=%0d busy=%b wr_en=%b, expected 0001/0/1/0",
                         c, gnt, sel, busy, wr_en);
            end
            tick();
        end
        stall = 1'b0;
        #1;
        writes += int'(wr_en);
        tick();
        req = 4'b0000;
        writes += int'(wr_en);
        n_cmp++;
        if (writes != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stall_one_write: got writes=%0d busy=%b, expected 1/0", writes, busy);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got wr_en=%b busy=%b gnt=%b, expected 0/0/0000",
                     wr_en, busy, gnt);
        end
        do_reset();
    endtask

    task automatic test_priority();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b1011;
        tick();
        req[1] = 1'b0;
`ifdef WB_ARB_FIXED_PRIO_EN
        exp_g = 4'b0001;
`else
        exp_g = 4'b1000;
`endif
        n_cmp++;
        if (gnt !== exp_g) begin
            n_fail++;
            $display("[TB] FAIL priority_after_1: got gnt=%b, expected %b", gnt, exp_g);
        end
`ifdef WB_ARB_FIXED_PRIO_EN
        tick();
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL fixed_masked_0: got gnt=%b, expected 1000", gnt);
        end
        tick();
        req[3] = 1'b0;
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL fixed_reassert_0: got gnt=%b, expected 0001", gnt);
        end
`endif
        req = 4'b0000;
        do_reset();
    endtask

    task automatic test_random();
        logic [3:0] exp_g;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (m_rel >= 0) begin
                req[m_rel]  = 1'b0;
                lock[m_rel] = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && i != m_rel && $urandom_range(0, 3) == 0) begin
                    req[i]  = 1'b1;
                    lock[i] = ($urandom_range(0, 2) == 0);
                end
            end
            stall = ($urandom_range(0, 5) == 0);
            #1;
            exp_g = (m_cur >= 0) ? (4'b0001 << m_cur) : 4'b0000;
            n_cmp++;
            if (gnt !== exp_g || busy !== (m_cur >= 0) || wr_en !== (m_cur >= 0 && !stall)
                || lock_err !== m_err) begin
                n_fail++;
                $display("[TB] FAIL random_c%0d: got gnt=%b busy=%b wr_en=%b lock_err=%b, expected %b/%b/%b/%b",
                         c, gnt, busy, wr_en, lock_err, exp_g, (m_cur >= 0), (m_cur >= 0 && !stall), m_err);
            end
            if (m_cur >= 0) begin
                n_cmp++;
                if (sel !== 2'(m_cur)) begin
                    n_fail++;
                    $display("[TB] FAIL random_sel_c%0d: got sel=%0d, expected %0d", c, sel, m_cur);
                end
            end
            tick();
        end
        stall = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_stall();
        test_async_reset();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
